// File: rtl/skein_pkg.sv
// Shared definitions for the Threefish-1024 round sequencer.
//   - Block geometry: words per subkey phase, rounds per block, subkey count.
//   - Counter widths for the word, round and subkey counters.
//   - Mode codes fed back from chip_mode_register.
//   - Sequencer FSM state enum.
package skein_pkg;

   localparam int NUM_WORDS         = 16;
   localparam int NUM_ROUNDS        = 80;
   localparam int ROUNDS_PER_SUBKEY = 4;
   localparam int NUM_SUBKEYS       = NUM_ROUNDS / ROUNDS_PER_SUBKEY + 1;

   localparam int WORD_CNT_W  = 4;
   localparam int ROUND_CNT_W = 7;
   localparam int SUBKEY_W    = 5;

   localparam logic [1:0] MODE_SKGEN   = 2'b00;
   localparam logic [1:0] MODE_SKADD   = 2'b01;
   localparam logic [1:0] MODE_TF      = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   // Subkey phases use all 16 words; a Threefish round takes 15 cycles because
   // the mode register picks its next mode at word 14 while in mode 10.
   localparam logic [WORD_CNT_W-1:0]  WORD_LAST_SK = WORD_CNT_W'(NUM_WORDS - 1);
   localparam logic [WORD_CNT_W-1:0]  WORD_LAST_TF = WORD_CNT_W'(NUM_WORDS - 2);
   localparam logic [ROUND_CNT_W-1:0] ROUND_LAST   = ROUND_CNT_W'(NUM_ROUNDS);
   localparam logic [SUBKEY_W-1:0]    SUBKEY_LAST  = SUBKEY_W'(NUM_SUBKEYS - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/skein_round_sequencer_if.sv
// Bus between the round sequencer and its parent / mode register.
//   start_i         parent -> sequencer, block start request
//   chip_mode_i     mode register -> sequencer, current mode
//   word_counter_o  current word index
//   round_counter_o completed Threefish rounds
//   subkey_index_o  subkey being generated or added
//   busy_o          block in progress
//   done_o          one-cycle block-finished pulse
//   error_o         one-cycle rejected-start / illegal-mode pulse
//   state_dbg_o     sequencer FSM state, for observation only
//
// Handshake: start_i acts as a valid with an implicit ready of (state == IDLE).
// A start is accepted only when it is high on a rising edge while the sequencer
// is idle and chip_mode_i == 00; acceptance is visible as busy_o the next cycle.
// A start seen in IDLE with any other mode is answered by a single error_o pulse.
// A start seen while busy is dropped silently. done_o is a one-cycle pulse with
// no back-pressure; the parent must capture it when it occurs.
interface skein_round_sequencer_if;
   import skein_pkg::*;

   logic                   start_i;
   logic [1:0]             chip_mode_i;
   logic [WORD_CNT_W-1:0]  word_counter_o;
   logic [ROUND_CNT_W-1:0] round_counter_o;
   logic [SUBKEY_W-1:0]    subkey_index_o;
   logic                   busy_o;
   logic                   done_o;
   logic                   error_o;
   seq_state_e             state_dbg_o;

   // Parent side: drives the request and the fed-back mode.
   modport master (
      output start_i, chip_mode_i,
      input  word_counter_o, round_counter_o, subkey_index_o,
      input  busy_o, done_o, error_o, state_dbg_o
   );

   // Sequencer side.
   modport slave (
      input  start_i, chip_mode_i,
      output word_counter_o, round_counter_o, subkey_index_o,
      output busy_o, done_o, error_o, state_dbg_o
   );

endinterface

// File: rtl/sequencer_wrap_counter.sv
// Up-counter with synchronous clear, enable and a runtime wrap value.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset, count -> 0
//   clr_i    synchronous clear, has priority over en_i
//   en_i     advance the count this cycle
//   wrap_i   last value before returning to 0
//   count_o  registered count
module sequencer_wrap_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] wrap_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Compare with >= so a count already above a newly lowered wrap value
   // returns to 0 instead of running past it.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = (count_q >= wrap_i) ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/skein_round_sequencer.sv
// Master counter stage for the Threefish-1024 core. Frames one block
// encryption (21 subkey gen/add pairs plus 80 rounds) and produces the word,
// round and subkey counters that steer chip_mode_register, following the mode
// that register feeds back.
//   clk_i  core clock, rising edge
//   rst_i  synchronous active-high reset; aborts a block with no done pulse
//   bus    skein_round_sequencer_if.slave: start_i, chip_mode_i in;
//          word/round/subkey counters, busy_o, done_o, error_o, state_dbg_o out
// All outputs are registered.
module skein_round_sequencer
   import skein_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   skein_round_sequencer_if.slave bus
);

   seq_state_e             state_d,  state_q;
   logic [ROUND_CNT_W-1:0] round_d,  round_q;
   logic [SUBKEY_W-1:0]    subkey_d, subkey_q;
   logic                   busy_d,   busy_q;
   logic                   done_d,   done_q;
   logic                   error_d,  error_q;

   logic                   word_clr;
   logic                   word_en;
   logic [WORD_CNT_W-1:0]  word_wrap;
   logic [WORD_CNT_W-1:0]  word_q;

   logic                   mode_skgen;
   logic                   mode_skadd;
   logic                   mode_tf;
   logic                   mode_bad;
   logic                   block_last;

   assign mode_skgen = (bus.chip_mode_i == MODE_SKGEN);
   assign mode_skadd = (bus.chip_mode_i == MODE_SKADD);
   assign mode_tf    = (bus.chip_mode_i == MODE_TF);
   assign mode_bad   = (bus.chip_mode_i == MODE_ILLEGAL);

   // Final word of the add phase of the last subkey, after all rounds.
   assign block_last = mode_skadd && (word_q == WORD_LAST_SK) &&
                       (subkey_q == SUBKEY_LAST) && (round_q == ROUND_LAST);

   assign word_wrap = mode_tf ? WORD_LAST_TF : WORD_LAST_SK;

   sequencer_wrap_counter #(
      .W (WORD_CNT_W)
   ) u_word_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (word_clr),
      .en_i    (word_en),
      .wrap_i  (word_wrap),
      .count_o (word_q)
   );

   // Next-state and counter updates. Word wrap, round increment and subkey
   // increment all look at the registered values only, so events that land
   // in the same cycle do not interact.
   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      subkey_d = subkey_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      word_clr = 1'b0;
      word_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               if (mode_skgen) begin
                  state_d  = ST_RUN;
                  round_d  = '0;
                  subkey_d = '0;
                  word_clr = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (mode_bad) begin
               // Word counter is left where it stopped for post-mortem.
               state_d = ST_IDLE;
               error_d = 1'b1;
            end else if (block_last) begin
               state_d  = ST_IDLE;
               done_d   = 1'b1;
               word_clr = 1'b1;
            end else begin
               word_en = 1'b1;
               if (mode_tf && (word_q == WORD_LAST_TF) && (round_q != ROUND_LAST)) begin
                  round_d = round_q + ROUND_CNT_W'(1);
               end
               if (mode_skadd && (word_q == WORD_LAST_SK) && (subkey_q != SUBKEY_LAST)) begin
                  subkey_d = subkey_q + SUBKEY_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         round_q  <= '0;
         subkey_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         subkey_q <= subkey_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign bus.word_counter_o  = word_q;
   assign bus.round_counter_o = round_q;
   assign bus.subkey_index_o  = subkey_q;
   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
   assign bus.error_o         = error_q;
   assign bus.state_dbg_o     = state_q;

endmodule

// File: tb/tb_skein_round_sequencer.sv
`timescale 1ns/1ps
module tb_skein_round_sequencer;
   import skein_pkg::*;

   localparam int RUN_CYCLES = 21 * 32 + 80 * 15;  // 1872
   localparam int SB_W       = 23;                 // {latency[10:0], round[6:0], subkey[4:0]}

   typedef struct {
      logic       start;
      logic [1:0] mode;
      logic       exp_err;
      logic       exp_busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   skein_round_sequencer_if bus ();

   skein_round_sequencer dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_seen = 0;
   int word_seq_bad = 0;
   int tf_range_bad = 0;
   logic model_en = 1'b0;
   logic mon_en = 1'b0;
   logic seen_r0 = 1'b0;
   logic seen_r3 = 1'b0;
   logic [SB_W-1:0] exp_q[$];
   vec_t vecs[6];

   logic [1:0] p_mode;
   logic [3:0] p_word;
   logic [6:0] p_round;
   logic       p_busy;
   logic       p_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural chip_mode_register: registered, decides from the counters
   // of the current cycle. Goes back to 00 after the last subkey add.
   function automatic logic [1:0] model_next(input logic [1:0] m, input logic [3:0] w,
                                             input logic [6:0] r, input logic [4:0] s,
                                             input logic b);
      logic [1:0] n;
      n = m;
      if (b) begin
         case (m)
            2'b00: if (w == 4'd15) n = 2'b01;
            2'b01: if (w == 4'd15) n = (s == 5'd20) ? 2'b00 : 2'b10;
            2'b10: if (w == 4'd14 && r[1:0] == 2'b11) n = 2'b00;
            default: n = m;
         endcase
      end
      return n;
   endfunction

   // Scoreboard pop on done_o plus running checks on the counter sequence.
   task automatic monitor();
      logic [SB_W-1:0] e;
      logic [3:0] exp_w;
      if (p_done) chk("done_single_pulse", bus.done_o, 0);
      if (bus.done_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", bus.done_o, 0);
         end else begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - start_cyc, {21'd0, e[22:12]});
            chk("final_round", bus.round_counter_o, {25'd0, e[11:5]});
            chk("final_subkey", bus.subkey_index_o, {27'd0, e[4:0]});
            done_seen++;
         end
      end
      if (mon_en && p_busy === 1'b1 && bus.busy_o === 1'b1) begin
         if (p_mode == 2'b10 && p_word == 4'd14 && p_round == 7'd3 && !seen_r3) begin
            chk("r3w14_round", bus.round_counter_o, 4);
            chk("r3w14_word", bus.word_counter_o, 0);
            seen_r3 = 1'b1;
         end
         if (p_mode == 2'b10 && p_word == 4'd14 && p_round == 7'd0 && !seen_r0) begin
            chk("r0w14_round", bus.round_counter_o, 1);
            chk("r0w14_word", bus.word_counter_o, 0);
            seen_r0 = 1'b1;
         end
         exp_w = (p_mode == 2'b10 && p_word == 4'd14) ? 4'd0 : p_word + 4'd1;
         if (bus.word_counter_o !== exp_w) word_seq_bad++;
         if (bus.chip_mode_i == 2'b10 && bus.word_counter_o > 4'd14) tf_range_bad++;
      end
   endtask

   // One clock: sample pre-edge values, advance, update the mode model.
   task automatic step();
      logic [1:0] nm;
      nm = model_next(bus.chip_mode_i, bus.word_counter_o, bus.round_counter_o,
                      bus.subkey_index_o, bus.busy_o);
      p_mode  = bus.chip_mode_i;
      p_word  = bus.word_counter_o;
      p_round = bus.round_counter_o;
      p_busy  = bus.busy_o;
      p_done  = bus.done_o;
      @(posedge clk);
      #1;
      cyc++;
      if (model_en) bus.chip_mode_i = nm;
      monitor();
   endtask

   task automatic start_block(input logic expect_done);
      bus.chip_mode_i = 2'b00;
      bus.start_i = 1'b1;
      start_cyc = cyc;
      if (expect_done) exp_q.push_back({11'(RUN_CYCLES + 1), 7'd80, 5'd20});
      step();
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int guard;
      logic inj;
      guard = 0;
      done_seen = 0;
      while (done_seen == 0 && guard < 3000) begin
         inj = (cyc == start_cyc + 500);
         bus.start_i = inj;
         step();
         guard++;
         if (inj) begin
            chk("run_start_no_error", bus.error_o, 0);
            chk("run_start_busy", bus.busy_o, 1);
         end
      end
      bus.start_i = 1'b0;
      chk(name, done_seen, 1);
   endtask

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.chip_mode_i = 2'b00;

      // 1. reset and quiet idle
      repeat (3) step();
      rst = 1'b0;
      chk("rst_word", bus.word_counter_o, 0);
      chk("rst_round", bus.round_counter_o, 0);
      chk("rst_subkey", bus.subkey_index_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_error", bus.error_o, 0);
      chk("rst_state", bus.state_dbg_o, ST_IDLE);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_quiet", {bus.word_counter_o, bus.round_counter_o, bus.subkey_index_o,
                            bus.busy_o, bus.done_o, bus.error_o}, 0);
      end

      // start acceptance / rejection from IDLE, one vector per mode
      vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 2'b01, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 2'b10, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 2'b11, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 2'b00, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 2'b10, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         bus.start_i = vecs[i].start;
         bus.chip_mode_i = vecs[i].mode;
         step();
         bus.start_i = 1'b0;
         chk($sformatf("vec%0d_error", i), bus.error_o, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_busy", i), bus.busy_o, {31'd0, vecs[i].exp_busy});
         chk($sformatf("vec%0d_word", i), bus.word_counter_o, 0);
         step();
         chk($sformatf("vec%0d_error_clear", i), bus.error_o, 0);
         chk($sformatf("vec%0d_busy_hold", i), bus.busy_o, {31'd0, vecs[i].exp_busy});
         rst = 1'b1;
         bus.chip_mode_i = 2'b00;
         step();
         rst = 1'b0;
      end

      // 2/3/4. full block with the mode model, stray start at RUN cycle 500
      model_en = 1'b1;
      mon_en = 1'b1;
      start_block(1'b1);
      chk("busy_rise", bus.busy_o, 1);
      chk("start_word", bus.word_counter_o, 0);
      chk("start_state", bus.state_dbg_o, ST_RUN);
      wait_done("block1_done");
      chk("post_done_busy", bus.busy_o, 0);
      chk("post_done_word", bus.word_counter_o, 0);
      chk("post_done_state", bus.state_dbg_o, ST_IDLE);
      repeat (5) step();
      chk("idle_hold_round", bus.round_counter_o, 80);
      chk("idle_hold_subkey", bus.subkey_index_o, 20);
      chk("idle_hold_word", bus.word_counter_o, 0);
      chk("seen_round0_wrap", seen_r0, 1);
      chk("seen_round3_wrap", seen_r3, 1);
      chk("word_sequence_errors", word_seq_bad, 0);
      chk("tf_word_range_errors", tf_range_bad, 0);

      // 5. reset at RUN cycle 700 aborts; a fresh block still completes
      start_block(1'b1);
      while (cyc < start_cyc + 700) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      chk("abort_word", bus.word_counter_o, 0);
      chk("abort_round", bus.round_counter_o, 0);
      chk("abort_subkey", bus.subkey_index_o, 0);
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_state", bus.state_dbg_o, ST_IDLE);
      bus.chip_mode_i = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_no_done", bus.done_o, 0);
      end
      start_block(1'b1);
      wait_done("block2_done");

      // 6. round saturation under forced mode 10, then illegal mode 11
      start_block(1'b0);
      begin
         int guard;
         logic [3:0] held;
         guard = 0;
         while (bus.round_counter_o != 7'd80 && guard < 3000) begin
            step();
            guard++;
         end
         chk("reach_round80", bus.round_counter_o, 80);
         model_en = 1'b0;
         mon_en = 1'b0;
         bus.chip_mode_i = 2'b10;
         repeat (20) step();
         chk("round_saturate", bus.round_counter_o, 80);
         chk("saturate_busy", bus.busy_o, 1);
         held = bus.word_counter_o;
         bus.chip_mode_i = 2'b11;
         step();
         chk("illegal_error", bus.error_o, 1);
         chk("illegal_busy", bus.busy_o, 0);
         chk("illegal_state", bus.state_dbg_o, ST_IDLE);
         chk("illegal_word_held", bus.word_counter_o, {28'd0, held});
         step();
         chk("illegal_error_clear", bus.error_o, 0);
         chk("illegal_word_still", bus.word_counter_o, {28'd0, held});
         chk("illegal_no_done", bus.done_o, 0);
      end
      bus.chip_mode_i = 2'b00;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
